// File: rtl/spi_slave_ctrl.sv
// SPI slave front end for a small command/response memory.
// A frame starts with one command bit (0 = write, 1 = read) followed by a
// 10-bit word, MSB first. Read-data frames stream one memory byte back on MISO.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | SS_n high or frame just aborted; waiting for SS_n low
// CHK_CMD   | next sampled MOSI bit picks write / read-address / read-data
// WRITE     | shifting a 10-bit write word (address or data)
// READ_ADD  | shifting a 10-bit read address; sets rd_addr_flag when done
// READ_DATA | shifting a 10-bit read word, then returning one byte on MISO

module spi_slave_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic       SS_n,
    input  logic       MOSI,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic [9:0] rx_data,
    output logic       rx_valid,
    output logic       MISO
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        CHK_CMD   = 3'd1,
        WRITE     = 3'd2,
        READ_ADD  = 3'd3,
        READ_DATA = 3'd4
    } state_t;

    state_t     state;
    state_t     next_state;

    // First nine bits of the word; the tenth is taken straight from MOSI.
    logic [8:0] rx_shift;
    logic [3:0] bit_cnt;
    logic       frame_done;
    logic       rd_addr_flag;

    // Read-data return path: byte shifter and remaining-bit down-counter.
    logic [7:0] tx_shift;
    logic [3:0] tx_cnt;
    logic       tx_captured;

    logic       in_frame;
    logic       shift_en;
    logic       last_bit;
    logic       capture_en;
    logic       tx_busy;
    logic       tx_last;

    // Datapath enables shared by the register blocks below.
    always_comb begin
        in_frame   = (state == WRITE) || (state == READ_ADD) || (state == READ_DATA);
        shift_en   = in_frame && !SS_n && !frame_done;
        last_bit   = shift_en && (bit_cnt == 4'd9);
        tx_busy    = (tx_cnt != 4'd0);
        capture_en = (state == READ_DATA) && !SS_n && frame_done &&
                     !tx_captured && tx_valid;
        tx_last    = (state == READ_DATA) && !SS_n && (tx_cnt == 4'd1);
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode; SS_n high always wins and returns to IDLE.
    always_comb begin
        next_state = state;
        if (SS_n) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE:      next_state = CHK_CMD;
                CHK_CMD: begin
                    if (!MOSI) begin
                        next_state = WRITE;
                    end else if (rd_addr_flag) begin
                        next_state = READ_DATA;
                    end else begin
                        next_state = READ_ADD;
                    end
                end
                WRITE:     next_state = WRITE;
                READ_ADD:  next_state = READ_ADD;
                READ_DATA: next_state = READ_DATA;
                default:   next_state = IDLE;
            endcase
        end
    end

    // Receive shifter and bit counter; cleared outside a live word so that an
    // aborted frame leaves nothing behind and CHK_CMD always hands over a zero count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_shift   <= 9'd0;
            bit_cnt    <= 4'd0;
            frame_done <= 1'b0;
        end else if (!in_frame || SS_n) begin
            rx_shift   <= 9'd0;
            bit_cnt    <= 4'd0;
            frame_done <= 1'b0;
        end else if (shift_en) begin
            rx_shift <= {rx_shift[7:0], MOSI};
            if (last_bit) begin
                bit_cnt    <= 4'd0;
                frame_done <= 1'b1;
            end else begin
                bit_cnt <= bit_cnt + 4'd1;
            end
        end
    end

    // Word output register and its one-cycle valid strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_data  <= 10'h000;
            rx_valid <= 1'b0;
        end else begin
            rx_valid <= last_bit;
            if (last_bit) begin
                rx_data <= {rx_shift, MOSI};
            end
        end
    end

    // Remembers that a read address has been delivered until its data byte is sent.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_addr_flag <= 1'b0;
        end else if (last_bit && (state == READ_ADD)) begin
            rd_addr_flag <= 1'b1;
        end else if (tx_last) begin
            rd_addr_flag <= 1'b0;
        end
    end

    // Read-data byte: captured once per frame, then shifted out MSB first.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_shift    <= 8'h00;
            tx_cnt      <= 4'd0;
            tx_captured <= 1'b0;
        end else if (SS_n || (state != READ_DATA)) begin
            tx_shift    <= 8'h00;
            tx_cnt      <= 4'd0;
            tx_captured <= 1'b0;
        end else if (capture_en) begin
            tx_shift    <= tx_data;
            tx_cnt      <= 4'd8;
            tx_captured <= 1'b1;
        end else if (tx_busy) begin
            tx_shift <= {tx_shift[6:0], 1'b0};
            tx_cnt   <= tx_cnt - 4'd1;
        end
    end

    // MISO is driven only while a byte is in flight.
    always_comb begin
        MISO = tx_busy ? tx_shift[7] : 1'b0;
    end

endmodule

// File: tb/tb_spi_slave_ctrl.sv
// Directed bench for spi_slave_ctrl with a frame-level reference model.
module tb_spi_slave_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       SS_n = 1'b1;
    logic       MOSI = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic [9:0] rx_data;
    logic       rx_valid;
    logic       MISO;

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    spi_slave_ctrl dut (
        .clk      (clk),
        .rst      (rst),
        .SS_n     (SS_n),
        .MOSI     (MOSI),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .MISO     (MISO)
    );

    always #5 clk = ~clk;

    // Reference model: position within the frame, word accumulated so far,
    // the read-address flag and the index of the MISO bit being presented.
    typedef struct packed {
        logic [1:0] pos;     // 0 idle, 1 next edge is command, 2 in word/body
        logic [1:0] mode;    // 0 write, 1 read address, 2 read data
        logic [4:0] nbits;
        logic [9:0] word;
        logic       flag;
        logic       capt;
        logic [3:0] p;       // MISO bits presented so far (0 = none)
        logic [7:0] txd;
        logic       rv;
        logic [9:0] rd;
        logic       miso;
    } mstate_t;

    mstate_t m = '0;

    function automatic mstate_t model_step(mstate_t s, logic ss, logic mosi,
                                           logic txv, logic [7:0] txd);
        mstate_t r;
        int idx;
        r = s;
        r.rv = 1'b0;
        r.miso = 1'b0;
        if (ss) begin
            r.pos = 2'd0;
            r.p = 4'd0;
            r.capt = 1'b0;
        end else if (s.pos == 2'd0) begin
            r.pos = 2'd1;
        end else if (s.pos == 2'd1) begin
            r.pos = 2'd2;
            r.nbits = 5'd0;
            r.capt = 1'b0;
            r.p = 4'd0;
            r.mode = !mosi ? 2'd0 : (s.flag ? 2'd2 : 2'd1);
        end else if (s.nbits < 5'd10) begin
            r.word = {s.word[8:0], mosi};
            r.nbits = s.nbits + 5'd1;
            if (r.nbits == 5'd10) begin
                r.rv = 1'b1;
                r.rd = r.word;
                if (s.mode == 2'd1) r.flag = 1'b1;
            end
        end else if (s.mode == 2'd2) begin
            if (s.p == 4'd8) begin
                r.p = 4'd0;
                r.flag = 1'b0;
            end else if (s.p != 4'd0) begin
                r.p = s.p + 4'd1;
                idx = 8 - int'(r.p);
                r.miso = s.txd[idx];
            end else if (!s.capt && txv) begin
                r.capt = 1'b1;
                r.txd = txd;
                r.p = 4'd1;
                r.miso = txd[7];
            end
        end
        return r;
    endfunction

    // Advance the model on the same edges the DUT samples.
    always @(posedge clk or posedge rst) begin
        if (rst) m <= '0;
        else     m <= model_step(m, SS_n, MOSI, tx_valid, tx_data);
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Cycle-by-cycle comparison against the model, away from the sampling edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("rx_valid", 32'(rx_valid), 32'(m.rv));
            check("rx_data", 32'(rx_data), 32'(m.rd));
            check("miso", 32'(MISO), 32'(m.miso));
        end
    end

    int rv_count = 0;
    logic [9:0] last_rx = 10'h000;

    always @(negedge clk) begin
        if (rx_valid) begin
            rv_count <= rv_count + 1;
            last_rx  <= rx_data;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic frame_begin(input logic cmd);
        @(negedge clk);
        SS_n = 1'b0;
        MOSI = 1'b0;
        @(negedge clk);
        MOSI = cmd;
    endtask

    task automatic send_bits(input logic [9:0] w, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            MOSI = w[9 - i];
        end
    endtask

    task automatic frame_end();
        @(negedge clk);
        SS_n = 1'b1;
        MOSI = 1'b0;
        tick(2);
    endtask

    // Raise tx_valid for 'hold' cycles and record n MISO samples, first one
    // taken in the cycle after the capturing edge. tx_data changes after the
    // first cycle so that a second capture would be visible.
    task automatic pulse_collect(input logic [7:0] d, input int hold, input int n,
                                 output logic [31:0] v);
        @(negedge clk);
        tx_data = d;
        tx_valid = 1'b1;
        v = 32'h0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            v = {v[30:0], MISO};
            if (i == 0) tx_data = ~d;
            if (i == hold - 1) tx_valid = 1'b0;
        end
    endtask

    initial begin
        int rv0;
        logic [31:0] v;

        tick(3);
        check("reset_rx_data", 32'(rx_data), 32'h000);
        check("reset_rx_valid", 32'(rx_valid), 32'h0);
        check("reset_miso", 32'(MISO), 32'h0);
        chk_en = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        tick(2);

        // write address
        rv0 = rv_count;
        frame_begin(1'b0);
        send_bits(10'h005, 10);
        frame_end();
        check("wr_addr_pulses", 32'(rv_count - rv0), 32'd1);
        check("wr_addr_word", 32'(last_rx), 32'h005);
        check("model_wr_addr_word", 32'(m.rd), 32'h005);

        // write data, with extra bits after the tenth that must be ignored
        rv0 = rv_count;
        frame_begin(1'b0);
        send_bits(10'h1AA, 10);
        send_bits(10'h2C0, 4);
        frame_end();
        check("wr_data_pulses", 32'(rv_count - rv0), 32'd1);
        check("wr_data_word", 32'(last_rx), 32'h1AA);

        // read address sets the flag
        rv0 = rv_count;
        frame_begin(1'b1);
        send_bits(10'h205, 10);
        frame_end();
        check("rd_addr_pulses", 32'(rv_count - rv0), 32'd1);
        check("rd_addr_word", 32'(last_rx), 32'h205);

        // read data returns C3
        rv0 = rv_count;
        frame_begin(1'b1);
        send_bits(10'h3A5, 10);
        tick(3);
        pulse_collect(8'hC3, 1, 10, v);
        frame_end();
        check("rd_data_pulses", 32'(rv_count - rv0), 32'd1);
        check("rd_data_word", 32'(last_rx), 32'h3A5);
        check("rd_data_miso_c3", v, 32'h30C);

        // flag cleared: next read frame is a read address, no MISO activity
        rv0 = rv_count;
        frame_begin(1'b1);
        send_bits(10'h0AB, 10);
        tick(3);
        pulse_collect(8'hC3, 1, 10, v);
        frame_end();
        check("rd_addr2_pulses", 32'(rv_count - rv0), 32'd1);
        check("rd_addr2_miso_quiet", v, 32'h0);

        // tx_valid held 20 cycles: single capture, exactly 8 bits
        frame_begin(1'b1);
        send_bits(10'h3F0, 10);
        tick(2);
        pulse_collect(8'h5A, 20, 24, v);
        frame_end();
        check("held_tx_valid_miso", v, 32'h5A0000);

        // abort after 6 write bits, then a clean frame
        rv0 = rv_count;
        frame_begin(1'b0);
        send_bits(10'h3FF, 6);
        frame_end();
        check("abort_pulses", 32'(rv_count - rv0), 32'd0);
        rv0 = rv_count;
        frame_begin(1'b0);
        send_bits(10'h155, 10);
        frame_end();
        check("post_abort_pulses", 32'(rv_count - rv0), 32'd1);
        check("post_abort_word", 32'(last_rx), 32'h155);

        // SS_n rises on the edge that samples the tenth bit
        rv0 = rv_count;
        frame_begin(1'b0);
        send_bits(10'h2AA, 9);
        @(negedge clk);
        MOSI = 1'b0;
        SS_n = 1'b1;
        tick(2);
        check("ss_on_last_bit_pulses", 32'(rv_count - rv0), 32'd0);

        // reset during read-data shift-out
        frame_begin(1'b1);
        send_bits(10'h2F0, 10);
        frame_end();
        frame_begin(1'b1);
        send_bits(10'h1C7, 10);
        tick(3);
        @(negedge clk);
        tx_data = 8'hC3;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        tick(1);
        check("miso_before_rst", 32'(MISO), 32'h1);
        #2;
        rst = 1'b1;
        SS_n = 1'b1;
        MOSI = 1'b0;
        #1;
        check("miso_in_rst", 32'(MISO), 32'h0);
        check("rx_valid_in_rst", 32'(rx_valid), 32'h0);
        tick(3);
        @(negedge clk);
        rst = 1'b0;
        tick(2);

        // flag was cleared by reset: this frame is a read address
        rv0 = rv_count;
        frame_begin(1'b1);
        send_bits(10'h111, 10);
        tick(3);
        pulse_collect(8'hFF, 1, 10, v);
        frame_end();
        check("post_rst_pulses", 32'(rv_count - rv0), 32'd1);
        check("post_rst_word", 32'(last_rx), 32'h111);
        check("post_rst_miso_quiet", v, 32'h0);

        tick(2);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
